// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array datapath: partial-sum width,
// the saturation limits the quantizer also range-checks against, and the accumulator FSM states.
package systolic_pkg;

    localparam int PSW = 18;

    localparam logic signed [PSW-1:0] PSUM_MAX = 18'sh1FFFF;   //  131071
    localparam logic signed [PSW-1:0] PSUM_MIN = 18'sh20000;   // -131072

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } acc_state_t;

endpackage

// File: rtl/psum_accumulator_if.sv
// Beat input from the array and result output to the quantizer, both valid/ready.
// The accumulator sits on the slave side; the array/quantizer pair is the master.
interface psum_accumulator_if #(
    parameter int PSW = systolic_pkg::PSW
);
    logic                  in_valid;
    logic                  in_ready;
    logic signed [PSW-1:0] psi1, psi2, psi3, psi4;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [PSW-1:0] pso1, pso2, pso3, pso4;

    modport master (
        output in_valid, psi1, psi2, psi3, psi4, out_ready,
        input  in_ready, out_valid, pso1, pso2, pso3, pso4
    );

    modport slave (
        input  in_valid, psi1, psi2, psi3, psi4, out_ready,
        output in_ready, out_valid, pso1, pso2, pso3, pso4
    );
endinterface

// File: rtl/sat_add_lane.sv
// One-lane saturating add of a partial sum into an accumulator; purely combinational.
// No handshake; flags whenever the result had to be clamped.
module sat_add_lane
    import systolic_pkg::*;
(
    input  logic signed [PSW-1:0] acc,
    input  logic signed [PSW-1:0] psi,
    output logic signed [PSW-1:0] sum,
    output logic                  sat
);
    logic signed [PSW:0] wide;

    assign wide = {acc[PSW-1], acc} + {psi[PSW-1], psi};

    // Top two bits disagree only when the true sum left the PSW-bit range.
    always_comb begin
        sat = 1'b0;
        sum = wide[PSW-1:0];
        if (wide[PSW] != wide[PSW-1]) begin
            sat = 1'b1;
            sum = wide[PSW] ? PSUM_MIN : PSUM_MAX;
        end
    end
endmodule

// File: rtl/psum_accumulator.sv
// Accumulates num_tiles beats of four column partial sums with saturation; result valid 1 cycle after last beat.
// in_ready is high only in ACCUM; totals are held on out_valid until out_ready, then done pulses.
module psum_accumulator #(
    parameter int NUM_LANES = 4,
    parameter int PSW       = systolic_pkg::PSW,
    parameter int TCW       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TCW-1:0]  num_tiles,
    psum_accumulator_if.slave io,
    output logic            busy,
    output logic            done,
    output logic            sat
);
    import systolic_pkg::*;

    acc_state_t            state;
    logic [TCW-1:0]        cnt;
    logic [TCW-1:0]        tiles;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic signed [PSW-1:0] acc      [NUM_LANES];
    logic signed [PSW-1:0] psi      [NUM_LANES];
    logic signed [PSW-1:0] lane_sum [NUM_LANES];
    logic [NUM_LANES-1:0]  lane_sat;
    logic [TCW-1:0]        cnt_nxt;

    assign psi[0] = io.psi1;
    assign psi[1] = io.psi2;
    assign psi[2] = io.psi3;
    assign psi[3] = io.psi4;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        sat_add_lane u_lane (
            .acc (acc[l]),
            .psi (psi[l]),
            .sum (lane_sum[l]),
            .sat (lane_sat[l])
        );
    end

    assign cnt_nxt = cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            tiles       <= '0;
            sat         <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            for (int l = 0; l < NUM_LANES; l++) acc[l] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        for (int l = 0; l < NUM_LANES; l++) acc[l] <= '0;
                        cnt        <= '0;
                        tiles      <= (num_tiles == '0) ? TCW'(1) : num_tiles;
                        sat        <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (io.in_valid) begin
                        for (int l = 0; l < NUM_LANES; l++) acc[l] <= lane_sum[l];
                        if (|lane_sat) sat <= 1'b1;
                        cnt <= cnt_nxt;
                        if (cnt_nxt == tiles) begin
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state       <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.pso1      = acc[0];
    assign io.pso2      = acc[1];
    assign io.pso3      = acc[2];
    assign io.pso4      = acc[3];
endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;
    localparam int PMAX = 131071;
    localparam int PMIN = -131072;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] num_tiles;
    logic       busy, done, sat;

    psum_accumulator_if io ();

    psum_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_tiles (num_tiles),
        .io        (io),
        .busy      (busy),
        .done      (done),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int tiles;
        int nbeats;
        int b [4][4];
        int e [4];
        int esat;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_pso(input string name, input int e0, input int e1, input int e2, input int e3);
        check({name, ".pso1"}, io.pso1, e0);
        check({name, ".pso2"}, io.pso2, e1);
        check({name, ".pso3"}, io.pso3, e2);
        check({name, ".pso4"}, io.pso4, e3);
    endtask

    task automatic set_beat(input int v0, input int v1, input int v2, input int v3);
        io.psi1 = 18'(v0);
        io.psi2 = 18'(v1);
        io.psi3 = 18'(v2);
        io.psi4 = 18'(v3);
    endtask

    task automatic do_start(input int t);
        start     = 1'b1;
        num_tiles = 4'(t);
        tick();
        start = 1'b0;
    endtask

    // Behavioural model: clamp after every add, sticky flag on any clamp.
    function automatic int clamp_add(input int a, input int b, inout bit s);
        int r;
        r = a + b;
        if (r > PMAX) begin r = PMAX; s = 1'b1; end
        else if (r < PMIN) begin r = PMIN; s = 1'b1; end
        return r;
    endfunction

    task automatic handshake(input string name);
        io.out_ready = 1'b1;
        tick();
        io.out_ready = 1'b0;
        check({name, ".done"}, done, 1);
        check({name, ".busy_after"}, busy, 0);
        check({name, ".out_valid_after"}, io.out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int m [4];
        bit msat;
        int v [4];
        int t, n, gaps, hold;
        logic signed [17:0] snap1, snap4;

        rst = 1'b1; start = 1'b0; num_tiles = '0;
        io.in_valid = 1'b0; io.out_ready = 1'b0;
        set_beat(0, 0, 0, 0);

        vecs[0].tiles = 3; vecs[0].nbeats = 3;
        vecs[0].b = '{'{10, -5, 100, 0}, '{20, -5, -300, 0}, '{30, -5, 50, 1}, '{0, 0, 0, 0}};
        vecs[0].e = '{60, -15, -150, 1}; vecs[0].esat = 0;
        vecs[1].tiles = 2; vecs[1].nbeats = 2;
        vecs[1].b = '{'{131000, -131000, 0, 0}, '{500, -500, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        vecs[1].e = '{131071, -131072, 0, 0}; vecs[1].esat = 1;
        vecs[2].tiles = 0; vecs[2].nbeats = 1;
        vecs[2].b = '{'{7, 7, 7, 7}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        vecs[2].e = '{7, 7, 7, 7}; vecs[2].esat = 0;
        vecs[3].tiles = 4; vecs[3].nbeats = 4;
        vecs[3].b = '{'{-131072, 131071, 5, -5}, '{-1, 1, 5, -5}, '{1, -1, 0, 0}, '{0, 0, -10, 10}};
        vecs[3].e = '{-131071, 131070, 0, 0}; vecs[3].esat = 1;

        tick(); tick();
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.sat", sat, 0);
        check("reset.in_ready", io.in_ready, 0);
        check("reset.out_valid", io.out_valid, 0);
        check_pso("reset", 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // Table-driven runs with continuous in_valid and immediate out_ready.
        for (int i = 0; i < 4; i++) begin
            do_start(vecs[i].tiles);
            check("vec.busy", busy, 1);
            check("vec.in_ready", io.in_ready, 1);
            for (int k = 0; k < vecs[i].nbeats; k++) begin
                check("vec.in_ready_beat", io.in_ready, 1);
                io.in_valid = 1'b1;
                set_beat(vecs[i].b[k][0], vecs[i].b[k][1], vecs[i].b[k][2], vecs[i].b[k][3]);
                tick();
            end
            io.in_valid = 1'b0;
            check("vec.out_valid", io.out_valid, 1);
            check("vec.in_ready_out", io.in_ready, 0);
            check_pso("vec", vecs[i].e[0], vecs[i].e[1], vecs[i].e[2], vecs[i].e[3]);
            check("vec.sat", sat, vecs[i].esat);
            check("vec.done_early", done, 0);
            handshake("vec");
            tick();
            check("vec.done_once", done, 0);
        end

        // Gapped in_valid, then a long stall in OUT with ignored start/in_valid.
        do_start(4);
        begin
            bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
            int bv = 1;
            for (int k = 0; k < 7; k++) begin
                io.in_valid = pat[k];
                if (pat[k]) begin set_beat(bv, -bv, 1000 * bv, 7); bv++; end
                else set_beat(9999, 9999, 9999, 9999);
                tick();
            end
        end
        io.in_valid = 1'b0;
        check("gap.out_valid", io.out_valid, 1);
        check_pso("gap", 10, -10, 10000, 28);
        for (int k = 0; k < 5; k++) begin
            io.in_valid = 1'b1; start = 1'b1; num_tiles = 4'd1;
            set_beat(500, 500, 500, 500);
            tick();
            check("stall.in_ready", io.in_ready, 0);
            check("stall.out_valid", io.out_valid, 1);
            check_pso("stall", 10, -10, 10000, 28);
        end
        io.in_valid = 1'b0;
        handshake("stall");
        start = 1'b0;
        check("stall.start_ignored", io.in_ready, 0);

        // Reset mid-run.
        tick();
        do_start(5);
        for (int k = 0; k < 2; k++) begin
            io.in_valid = 1'b1; set_beat(100, -100, 200, -200);
            tick();
        end
        io.in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.in_ready", io.in_ready, 0);
        check("abort.out_valid", io.out_valid, 0);
        check_pso("abort", 0, 0, 0, 0);
        do_start(1);
        io.in_valid = 1'b1; set_beat(1, 1, 1, 1);
        tick();
        io.in_valid = 1'b0;
        check("fresh.out_valid", io.out_valid, 1);
        check_pso("fresh", 1, 1, 1, 1);
        handshake("fresh");

        // Back-to-back: start in the done cycle; sat and totals start clean.
        start = 1'b1; num_tiles = 4'd2;
        tick();
        start = 1'b0;
        check("b2b0.busy", busy, 1);
        io.in_valid = 1'b1; set_beat(131071, 0, 0, 0); tick();
        set_beat(1, 0, 0, 0); tick();
        io.in_valid = 1'b0;
        check("b2b0.sat", sat, 1);
        handshake("b2b0");
        start = 1'b1; num_tiles = 4'd1;
        tick();
        start = 1'b0;
        check("b2b1.busy", busy, 1);
        check("b2b1.sat_cleared", sat, 0);
        io.in_valid = 1'b1; set_beat(3, -3, 0, 0); tick();
        io.in_valid = 1'b0;
        check_pso("b2b1", 3, -3, 0, 0);
        check("b2b1.sat", sat, 0);
        handshake("b2b1");

        // Randomized runs against the model.
        for (int r = 0; r < 40; r++) begin
            t = $urandom_range(0, 15);
            n = (t == 0) ? 1 : t;
            m = '{0, 0, 0, 0};
            msat = 1'b0;
            do_start(t);
            for (int k = 0; k < n; k++) begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    io.in_valid = 1'b0; set_beat(77777, -77777, 1, 1);
                    tick();
                end
                check("rand.in_ready", io.in_ready, 1);
                for (int l = 0; l < 4; l++) begin
                    if ($urandom_range(0, 3) == 0) v[l] = ($urandom_range(0, 1) != 0) ? PMAX : PMIN;
                    else v[l] = int'($urandom_range(0, 262143)) - 131072;
                    m[l] = clamp_add(m[l], v[l], msat);
                end
                io.in_valid = 1'b1; set_beat(v[0], v[1], v[2], v[3]);
                tick();
            end
            io.in_valid = 1'b0;
            check("rand.out_valid", io.out_valid, 1);
            hold = $urandom_range(0, 3);
            snap1 = io.pso1; snap4 = io.pso4;
            for (int h = 0; h < hold; h++) tick();
            check("rand.hold_valid", io.out_valid, 1);
            check_pso("rand", m[0], m[1], m[2], m[3]);
            check("rand.stable1", io.pso1, int'(snap1));
            check("rand.stable4", io.pso4, int'(snap4));
            check("rand.sat", sat, int'(msat));
            handshake("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
